// File: rtl/uart_cpu_if_multi.sv
// uart_cpu_if_multi: 8-bit CPU register front-end for NCH UART channels.
// Each channel occupies 16 addresses starting at 16*c: data, status, divider
// low/high, interrupt enable and interrupt pending. Globals at 0x80..0x83
// hold the general outputs, the synchronised misc inputs, their sticky
// rising-edge flags and the per-channel interrupt summary.
// Optional feature: define UART_CPU_IF_MULTI_IRQ_EN to build the IE/IP
// registers, status edge history, the 0x83 summary and the irq output.
// Without it those registers read 0, ignore writes and irq is tied low.
module uart_cpu_if_multi #(
  parameter int NCH       = 4,
  parameter int DIV_W     = 16,
  parameter int DIV_RESET = 27
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             cpu_addr,
  input  logic [7:0]             cpu_data_in,
  input  logic                   rd,
  input  logic                   wr,
  output logic [7:0]             cpu_data_out,
  output logic [DIV_W*NCH-1:0]   uart_divider,
  output logic [NCH-1:0]         uart_tx_wr,
  output logic [NCH-1:0]         uart_rx_rd,
  output logic [7:0]             uart_tx_data,
  input  logic [8*NCH-1:0]       uart_rx_data,
  input  logic [6*NCH-1:0]       uart_status,
  input  logic [7:0]             misc_in,
  output logic [7:0]             misc_out,
  output logic                   irq
);

  localparam logic [7:0] ADDR_MISC_OUT  = 8'h80;
  localparam logic [7:0] ADDR_MISC_IN   = 8'h81;
  localparam logic [7:0] ADDR_MISC_EDGE = 8'h82;
  localparam logic [7:0] ADDR_IRQ_SUM   = 8'h83;

  localparam logic [3:0] OFF_DATA   = 4'd0;
  localparam logic [3:0] OFF_STAT   = 4'd1;
  localparam logic [3:0] OFF_DIV_LO = 4'd2;
  localparam logic [3:0] OFF_DIV_HI = 4'd3;
  localparam logic [3:0] OFF_IE     = 4'd4;
  localparam logic [3:0] OFF_IP     = 4'd5;

  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RESET);

  logic [3:0]       off;
  logic [NCH-1:0]   ch_sel;
  logic             wr_en;
  logic [DIV_W-1:0] div [NCH];
  logic [7:0]       rd_mux;
  logic [NCH-1:0]   irq_vec;

  // misc_in synchroniser stages plus one history flop for edge detection
  logic [7:0]       misc_p0, misc_p1, misc_p2, misc_hist;
  logic [7:0]       misc_edge;
  logic [7:0]       misc_edge_clr;

  // Return one byte of a divider; bits at or above DIV_W read as zero.
  function automatic logic [7:0] div_byte(input logic [DIV_W-1:0] d, input logic hi);
    logic [15:0] e;
    e = 16'(d);
    return hi ? e[15:8] : e[7:0];
  endfunction

  // Replace one byte of a divider, dropping bits that do not exist.
  function automatic logic [DIV_W-1:0] div_merge(input logic [DIV_W-1:0] d, input logic hi,
                                                 input logic [7:0] b);
    logic [15:0] e;
    e = 16'(d);
    if (hi) e[15:8] = b;
    else    e[7:0]  = b;
    return e[DIV_W-1:0];
  endfunction

  assign off   = cpu_addr[3:0];
  // A simultaneous read takes the bus cycle; the write is dropped.
  assign wr_en = wr & ~rd;

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_ch
      // Channel indices only reach 7, so addresses 0x80 and up never select a channel.
      assign ch_sel[g] = (cpu_addr[7:4] == 4'(g));
      assign uart_divider[g*DIV_W +: DIV_W] = div[g];
    end
  endgenerate

  assign misc_edge_clr = (wr_en && cpu_addr == ADDR_MISC_EDGE) ? cpu_data_in : 8'h00;

`ifdef UART_CPU_IF_MULTI_IRQ_EN
  logic [1:0]     ie [NCH];
  logic [1:0]     ip [NCH];
  logic [1:0]     ip_next [NCH];
  logic [NCH-1:0] rx_hist, txf_hist;

  // Pending update: W1C clear first, then new edges OR in so a set wins.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      ip_next[c] = ip[c];
      if (wr_en && ch_sel[c] && off == OFF_IP) ip_next[c] = ip[c] & ~cpu_data_in[1:0];
      ip_next[c][0] = ip_next[c][0] | (uart_status[c*6] & ~rx_hist[c]);
      ip_next[c][1] = ip_next[c][1] | (~uart_status[c*6+1] & txf_hist[c]);
      irq_vec[c] = |(ie[c] & ip[c]);
    end
  end

  // Interrupt state: enables, pending bits, status edge history and irq.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        ie[c] <= 2'b00;
        ip[c] <= 2'b00;
      end
      rx_hist  <= '0;
      txf_hist <= '0;
      irq      <= 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_en && ch_sel[c] && off == OFF_IE) ie[c] <= cpu_data_in[1:0];
        ip[c]       <= ip_next[c];
        rx_hist[c]  <= uart_status[c*6];
        txf_hist[c] <= uart_status[c*6+1];
      end
      irq <= |irq_vec;
    end
  end
`else
  assign irq_vec = '0;
  assign irq     = 1'b0;
`endif

  // Read multiplexer over globals and the selected channel's registers.
  always_comb begin
    rd_mux = 8'h00;
    case (cpu_addr)
      ADDR_MISC_OUT:  rd_mux = misc_out;
      ADDR_MISC_IN:   rd_mux = misc_p2;
      ADDR_MISC_EDGE: rd_mux = misc_edge;
      ADDR_IRQ_SUM:   rd_mux = 8'(irq_vec);
      default:        ;
    endcase
    for (int c = 0; c < NCH; c++) begin
      if (ch_sel[c]) begin
        case (off)
          OFF_DATA:   rd_mux = uart_rx_data[c*8 +: 8];
          OFF_STAT:   rd_mux = {2'b00, uart_status[c*6 +: 6]};
          OFF_DIV_LO: rd_mux = div_byte(div[c], 1'b0);
          OFF_DIV_HI: rd_mux = div_byte(div[c], 1'b1);
`ifdef UART_CPU_IF_MULTI_IRQ_EN
          OFF_IE:     rd_mux = {6'b000000, ie[c]};
          OFF_IP:     rd_mux = {6'b000000, ip[c]};
`endif
          default:    ;
        endcase
      end
    end
  end

  // Bus access: registered read data, one-cycle strobes and register writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_data_out <= 8'h00;
      uart_tx_data <= 8'h00;
      uart_tx_wr   <= '0;
      uart_rx_rd   <= '0;
      misc_out     <= 8'h00;
      for (int c = 0; c < NCH; c++) div[c] <= DIV_INIT;
    end else begin
      uart_tx_wr <= '0;
      uart_rx_rd <= '0;
      if (rd) begin
        cpu_data_out <= rd_mux;
        for (int c = 0; c < NCH; c++) begin
          if (ch_sel[c] && off == OFF_DATA) uart_rx_rd[c] <= 1'b1;
        end
      end else if (wr) begin
        if (cpu_addr == ADDR_MISC_OUT) misc_out <= cpu_data_in;
        for (int c = 0; c < NCH; c++) begin
          if (ch_sel[c]) begin
            case (off)
              OFF_DATA: begin
                uart_tx_data  <= cpu_data_in;
                uart_tx_wr[c] <= 1'b1;
              end
              OFF_DIV_LO: div[c] <= div_merge(div[c], 1'b0, cpu_data_in);
              OFF_DIV_HI: div[c] <= div_merge(div[c], 1'b1, cpu_data_in);
              default:    ;
            endcase
          end
        end
      end
    end
  end

  // misc_in three-flop synchroniser and sticky rising-edge flags (set wins over W1C).
  always_ff @(posedge clk) begin
    if (reset) begin
      misc_p0   <= 8'h00;
      misc_p1   <= 8'h00;
      misc_p2   <= 8'h00;
      misc_hist <= 8'h00;
      misc_edge <= 8'h00;
    end else begin
      misc_p0   <= misc_in;
      misc_p1   <= misc_p0;
      misc_p2   <= misc_p1;
      misc_hist <= misc_p2;
      misc_edge <= (misc_edge & ~misc_edge_clr) | (misc_p2 & ~misc_hist);
    end
  end

endmodule

// File: tb/tb_uart_cpu_if_multi.sv
// tb_uart_cpu_if_multi: directed bench for uart_cpu_if_multi with a register
// level reference model checked every cycle, plus hand-computed expectations.
// A second instance (NCH=2, DIV_W=12) shares the CPU bus for the narrow cases.
`timescale 1ns/1ps
module tb_uart_cpu_if_multi;

  localparam int NCH   = 4;
  localparam int DIV_W = 16;
  localparam int NCH2  = 2;
  localparam int DIV_W2 = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] cpu_addr = 8'h00;
  logic [7:0] cpu_data_in = 8'h00;
  logic rd = 1'b0;
  logic wr = 1'b0;
  logic [7:0] misc_in = 8'h00;

  logic [7:0]             cpu_data_out;
  logic [DIV_W*NCH-1:0]   uart_divider;
  logic [NCH-1:0]         uart_tx_wr, uart_rx_rd;
  logic [7:0]             uart_tx_data;
  logic [8*NCH-1:0]       uart_rx_data = '0;
  logic [6*NCH-1:0]       uart_status = '0;
  logic [7:0]             misc_out;
  logic                   irq;

  logic [7:0]             cpu_data_out2;
  logic [DIV_W2*NCH2-1:0] uart_divider2;
  logic [NCH2-1:0]        uart_tx_wr2, uart_rx_rd2;
  logic [7:0]             uart_tx_data2;
  logic [8*NCH2-1:0]      uart_rx_data2 = 16'h5A5A;
  logic [6*NCH2-1:0]      uart_status2 = '0;
  logic [7:0]             misc_out2;
  logic                   irq2;

  int n_tests = 0;
  int n_fail  = 0;

  uart_cpu_if_multi #(.NCH(NCH), .DIV_W(DIV_W), .DIV_RESET(27)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .rd(rd), .wr(wr), .cpu_data_out(cpu_data_out), .uart_divider(uart_divider),
    .uart_tx_wr(uart_tx_wr), .uart_rx_rd(uart_rx_rd), .uart_tx_data(uart_tx_data),
    .uart_rx_data(uart_rx_data), .uart_status(uart_status), .misc_in(misc_in),
    .misc_out(misc_out), .irq(irq)
  );

  uart_cpu_if_multi #(.NCH(NCH2), .DIV_W(DIV_W2), .DIV_RESET(27)) dut2 (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in),
    .rd(rd), .wr(wr), .cpu_data_out(cpu_data_out2), .uart_divider(uart_divider2),
    .uart_tx_wr(uart_tx_wr2), .uart_rx_rd(uart_rx_rd2), .uart_tx_data(uart_tx_data2),
    .uart_rx_data(uart_rx_data2), .uart_status(uart_status2), .misc_in(misc_in),
    .misc_out(misc_out2), .irq(irq2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (register-map semantics) ----------------
  bit         m_valid = 1'b0;
  logic [7:0] m_dout, m_tx, m_misc_out, m_edge, m_sync_prev;
  logic [7:0] m_samp [3];
  logic [NCH-1:0] m_rxrd, m_txwr;
  logic [15:0] m_div [NCH];
  logic [1:0]  m_ie [NCH];
  logic [1:0]  m_ip [NCH];
  logic        m_rx_prev [NCH];
  logic        m_txf_prev [NCH];
  logic        m_irq;

  function automatic logic [7:0] m_read(input logic [7:0] a);
    int c = int'(a) / 16;
    int o = int'(a) % 16;
    logic [7:0] v = 8'h00;
    if (a == 8'h80) v = m_misc_out;
    else if (a == 8'h81) v = m_samp[2];
    else if (a == 8'h82) v = m_edge;
`ifdef UART_CPU_IF_MULTI_IRQ_EN
    else if (a == 8'h83) begin
      for (int k = 0; k < NCH; k++) v[k] = |(m_ie[k] & m_ip[k]);
    end
`endif
    else if (int'(a) < 16 * NCH) begin
      case (o)
        0: v = uart_rx_data[c*8 +: 8];
        1: v = {2'b00, uart_status[c*6 +: 6]};
        2: v = m_div[c][7:0];
        3: v = m_div[c][15:8];
`ifdef UART_CPU_IF_MULTI_IRQ_EN
        4: v = {6'b000000, m_ie[c]};
        5: v = {6'b000000, m_ip[c]};
`endif
        default: v = 8'h00;
      endcase
    end
    return v;
  endfunction

  always @(posedge clk) begin : model
    int c;
    int o;
    logic [7:0] eset;
`ifdef UART_CPU_IF_MULTI_IRQ_EN
    logic [1:0] ipset [NCH];
    logic irqn;
`endif
    m_valid = 1'b1;
    if (reset) begin
      m_dout = 0; m_tx = 0; m_misc_out = 0; m_edge = 0; m_sync_prev = 0;
      m_rxrd = 0; m_txwr = 0; m_irq = 0;
      for (int k = 0; k < 3; k++) m_samp[k] = 8'h00;
      for (int k = 0; k < NCH; k++) begin
        m_div[k] = 16'd27; m_ie[k] = 0; m_ip[k] = 0;
        m_rx_prev[k] = 0; m_txf_prev[k] = 0;
      end
    end else begin
      c = int'(cpu_addr) / 16;
      o = int'(cpu_addr) % 16;
`ifdef UART_CPU_IF_MULTI_IRQ_EN
      irqn = 1'b0;
      for (int k = 0; k < NCH; k++) begin
        irqn = irqn | (|(m_ie[k] & m_ip[k]));
        ipset[k] = {m_txf_prev[k] & ~uart_status[k*6+1], uart_status[k*6] & ~m_rx_prev[k]};
      end
`endif
      eset = m_samp[2] & ~m_sync_prev;
      m_rxrd = 0;
      m_txwr = 0;
      if (rd) begin
        m_dout = m_read(cpu_addr);
        if (int'(cpu_addr) < 16 * NCH && o == 0) m_rxrd[c] = 1'b1;
      end else if (wr) begin
        if (cpu_addr == 8'h80) m_misc_out = cpu_data_in;
        else if (cpu_addr == 8'h82) m_edge = m_edge & ~cpu_data_in;
        else if (int'(cpu_addr) < 16 * NCH) begin
          case (o)
            0: begin m_tx = cpu_data_in; m_txwr[c] = 1'b1; end
            2: m_div[c][7:0]  = cpu_data_in;
            3: m_div[c][15:8] = cpu_data_in;
`ifdef UART_CPU_IF_MULTI_IRQ_EN
            4: m_ie[c] = cpu_data_in[1:0];
            5: m_ip[c] = m_ip[c] & ~cpu_data_in[1:0];
`endif
            default: ;
          endcase
        end
      end
`ifdef UART_CPU_IF_MULTI_IRQ_EN
      for (int k = 0; k < NCH; k++) m_ip[k] = m_ip[k] | ipset[k];
      m_irq = irqn;
`endif
      m_edge = m_edge | eset;
      m_sync_prev = m_samp[2];
      m_samp[2] = m_samp[1];
      m_samp[1] = m_samp[0];
      m_samp[0] = misc_in;
      for (int k = 0; k < NCH; k++) begin
        m_rx_prev[k]  = uart_status[k*6];
        m_txf_prev[k] = uart_status[k*6+1];
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : compare
    logic [63:0] exp_div;
    if (m_valid) begin
      for (int k = 0; k < NCH; k++) exp_div[k*16 +: 16] = m_div[k];
      chk("cmp_dout",   cpu_data_out, m_dout);
      chk("cmp_rx_rd",  uart_rx_rd,   m_rxrd);
      chk("cmp_tx_wr",  uart_tx_wr,   m_txwr);
      chk("cmp_tx_dat", uart_tx_data, m_tx);
      chk("cmp_misc",   misc_out,     m_misc_out);
      chk("cmp_div",    uart_divider, exp_div);
      chk("cmp_irq",    irq,          m_irq);
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read(input logic [7:0] a);
    cpu_addr = a; rd = 1'b1; wr = 1'b0;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_data_in = d; wr = 1'b1; rd = 1'b0;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic set_stat(input int c, input logic [5:0] v);
    uart_status[c*6 +: 6] = v;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int pulses;
    // Reset held with a pending read and write: neither may take effect.
    reset = 1'b1; rd = 1'b1; wr = 1'b1; cpu_addr = 8'h00; cpu_data_in = 8'h99;
    uart_rx_data[7:0] = 8'h3C;
    idle(3);
    chk("rst_dout",  cpu_data_out, 8'h00);
    chk("rst_rx_rd", uart_rx_rd, 4'b0000);
    chk("rst_tx_wr", uart_tx_wr, 4'b0000);
    chk("rst_txdat", uart_tx_data, 8'h00);
    chk("rst_div",   uart_divider, {4{16'd27}});
    chk("rst_irq",   irq, 1'b0);
    rd = 1'b0; wr = 1'b0; reset = 1'b0;

    do_read(8'h12);
    chk("div1_lo", cpu_data_out, 8'h1B);
    chk("div1_lo_strobes", {uart_rx_rd, uart_tx_wr}, 8'h00);
    do_read(8'h13);
    chk("div1_hi", cpu_data_out, 8'h00);

    do_write(8'h20, 8'h41);
    chk("tx_data", uart_tx_data, 8'h41);
    chk("tx_wr_ch2", uart_tx_wr, 4'b0100);
    idle(1);
    chk("tx_wr_one_cycle", uart_tx_wr, 4'b0000);

    uart_rx_data[31:24] = 8'hA5;
    do_read(8'h30);
    chk("rx_data_ch3", cpu_data_out, 8'hA5);
    chk("rx_rd_ch3", uart_rx_rd, 4'b1000);
    cpu_addr = 8'h30; cpu_data_in = 8'h77; rd = 1'b1; wr = 1'b1;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    chk("rdwr_no_tx", uart_tx_wr, 4'b0000);
    chk("rdwr_tx_kept", uart_tx_data, 8'h41);
    chk("rdwr_rx_rd", uart_rx_rd, 4'b1000);

    // Back-to-back writes and reads: one strobe per cycle.
    pulses = 0;
    cpu_addr = 8'h00; wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_data_in = 8'(i + 1);
      @(negedge clk);
      if (uart_tx_wr == 4'b0001) pulses++;
    end
    wr = 1'b0;
    chk("burst_tx_pulses", pulses, 3);
    chk("burst_tx_last", uart_tx_data, 8'h03);
    pulses = 0;
    cpu_addr = 8'h30; rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (uart_rx_rd == 4'b1000) pulses++;
    end
    rd = 1'b0;
    chk("burst_rx_pulses", pulses, 3);

    do_write(8'h02, 8'h34);
    do_write(8'h03, 8'h12);
    chk("div0_write", uart_divider[15:0], 16'h1234);
    do_read(8'h02);
    chk("div0_lo_rd", cpu_data_out, 8'h34);
    do_read(8'h40);
    chk("unmapped_ch4", cpu_data_out, 8'h00);
    chk("unmapped_ch4_strobe", uart_rx_rd, 4'b0000);
    do_read(8'h02);
    do_read(8'h07);
    chk("unmapped_off7", cpu_data_out, 8'h00);
    do_write(8'h40, 8'hEE);
    chk("unmapped_wr_no_tx", uart_tx_wr, 4'b0000);

    do_write(8'h80, 8'h5A);
    chk("misc_out", misc_out, 8'h5A);
    do_write(8'h81, 8'hFF);
    do_read(8'h80);
    chk("misc_out_rd", cpu_data_out, 8'h5A);

    set_stat(1, 6'h2D);
    do_read(8'h11);
    chk("status_ch1", cpu_data_out, 8'h2D);

    misc_in = 8'h04;
    idle(2);
    do_read(8'h81);
    chk("sync_not_yet", cpu_data_out, 8'h00);
    do_read(8'h81);
    chk("sync_after_3", cpu_data_out, 8'h04);
    do_read(8'h82);
    chk("edge_set", cpu_data_out, 8'h04);
    do_write(8'h82, 8'h04);
    do_read(8'h82);
    chk("edge_w1c", cpu_data_out, 8'h00);

`ifdef UART_CPU_IF_MULTI_IRQ_EN
    set_stat(1, 6'h00);
    idle(2);
    do_write(8'h15, 8'h03);
    do_write(8'h14, 8'h01);
    set_stat(1, 6'h01);
    idle(1);
    chk("irq_not_yet", irq, 1'b0);
    idle(1);
    chk("irq_set", irq, 1'b1);
    do_read(8'h15);
    chk("ip_ch1", cpu_data_out, 8'h01);
    do_read(8'h83);
    chk("irq_sum", cpu_data_out, 8'h02);
    do_write(8'h15, 8'h01);
    idle(1);
    chk("irq_cleared", irq, 1'b0);
    set_stat(1, 6'h00);
    idle(1);
    set_stat(1, 6'h01);
    do_write(8'h15, 8'h01);
    do_read(8'h15);
    chk("ip_set_wins", cpu_data_out, 8'h01);
    chk("irq_after_set_wins", irq, 1'b1);
    set_stat(1, 6'h03);
    idle(1);
    set_stat(1, 6'h01);
    idle(1);
    do_read(8'h15);
    chk("ip_txfull_fall", cpu_data_out, 8'h03);
    do_write(8'h14, 8'h00);
    idle(2);
    chk("irq_ie_off", irq, 1'b0);
`else
    set_stat(1, 6'h00);
    idle(1);
    set_stat(1, 6'h01);
    do_write(8'h14, 8'h03);
    do_read(8'h14);
    chk("noirq_ie", cpu_data_out, 8'h00);
    do_read(8'h15);
    chk("noirq_ip", cpu_data_out, 8'h00);
    do_read(8'h83);
    chk("noirq_sum", cpu_data_out, 8'h00);
    chk("noirq_irq", irq, 1'b0);
`endif

    // Narrow instance: 12-bit dividers and only two channels.
    do_write(8'h03, 8'hFF);
    do_read(8'h03);
    chk("n2_div_hi", cpu_data_out2, 8'h0F);
    chk("n2_div_pack", uart_divider2[11:0], 12'hF34);
    chk("main_div_hi", cpu_data_out, 8'hFF);
    do_read(8'h20);
    chk("n2_ch2_unmapped", cpu_data_out2, 8'h00);
    chk("n2_ch2_no_strobe", uart_rx_rd2, 2'b00);

    // Reset arriving together with a data read suppresses both effects.
    cpu_addr = 8'h30; rd = 1'b1; reset = 1'b1;
    @(negedge clk);
    chk("midrst_dout", cpu_data_out, 8'h00);
    chk("midrst_rx_rd", uart_rx_rd, 4'b0000);
    chk("midrst_div", uart_divider, {4{16'd27}});
    rd = 1'b0; reset = 1'b0;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cpu_if_multi.md
UART_CPU_IF_MULTI -- requirements
Module: uart_cpu_if_multi

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of UART channels (legal 1..8).
REQ-002 SHALL have parameter DIV_W, default 16, meaning divider width in bits (legal 8..16).
REQ-003 SHALL have parameter DIV_RESET, default 27, meaning divider reset value for every channel.
REQ-004 Port clk  input  1  clock; all logic on its rising edge.
REQ-005 Port reset  input  1  reset, synchronous, active-high.
REQ-006 Port cpu_addr  input  8  register address.
REQ-007 Port cpu_data_in  input  8  write data.
REQ-008 Port rd / wr  input  1 each  read / write request, one access per high cycle.
REQ-009 Port cpu_data_out  output  8  registered read data.
REQ-010 Port uart_divider  output  DIV_W*NCH  packed dividers, channel c at [c*DIV_W +: DIV_W].
REQ-011 Port uart_tx_wr / uart_rx_rd  output  NCH each  one-cycle push / pop strobes.
REQ-012 Port uart_tx_data  output  8  registered transmit byte shared by all channels.
REQ-013 Port uart_rx_data  input  8*NCH  packed receive bytes.
REQ-014 Port uart_status  input  6*NCH  packed status; bit0 = rx_avail, bit1 = tx_full.
REQ-015 Port misc_in  input  8  asynchronous inputs; port misc_out  output  8  general outputs.
REQ-016 Port irq  output  1  registered interrupt request.

Function
REQ-017 Channel c base = 16*c; offsets: +0 data, +1 status, +2 div[7:0], +3 div[15:8], +4 IE[1:0], +5 IP[1:0]; globals: 0x80 misc_out, 0x81 misc_in_sync, 0x82 misc_edge, 0x83 irq summary (bit c = channel c).
REQ-018 Read data SHALL appear on cpu_data_out exactly one cycle after rd; unmapped addresses and unimplemented bits, including divider bits at or above DIV_W, return 0.
REQ-019 Read of +0 SHALL return uart_rx_data of channel c and pulse uart_rx_rd[c] for one cycle in the same cycle as the data update.
REQ-020 Write of +0 SHALL load uart_tx_data with cpu_data_in and pulse uart_tx_wr[c] for one cycle on the next edge.
REQ-021 Writes to +1, 0x81, 0x83 and unmapped addresses SHALL be ignored; misc_out write takes cpu_data_in.
REQ-022 rd and wr high in the same cycle: rd serviced, wr discarded.
REQ-023 Continuous rd or wr SHALL produce one strobe per high cycle, with no coalescing.
REQ-024 misc_in SHALL pass through a 3-flop synchronizer; misc_edge bit sets on a 0->1 of the synchronized value, is sticky, and clears by writing 1 (W1C).
REQ-025 IP bit0 SHALL set on a rising edge of rx_avail; IP bit1 SHALL set on a falling edge of tx_full; IP is W1C; set wins over simultaneous clear.
REQ-026 irq SHALL equal the OR over channels of (IE & IP), registered, asserting one cycle after the IP set.
REQ-027 Channels with index at or above NCH SHALL be unmapped.

Reset
REQ-028 Reset SHALL set cpu_data_out, misc_out, uart_tx_data, strobes, IE, IP, misc_edge, synchronizer flops, edge-history flops and irq to 0, and every divider to DIV_RESET.
REQ-029 Reset asserted mid-access SHALL suppress that access's strobe and its read update.

Configuration
REQ-030 Macro UART_CPU_IF_MULTI_IRQ_EN defined: IE, IP, edge history, 0x83 and irq are implemented per REQ-025/026.
REQ-031 Macro UART_CPU_IF_MULTI_IRQ_EN undefined: no IE/IP logic, +4/+5/0x83 read 0, writes ignored, irq tied 0.

Verification
REQ-032 Reset, then read 0x12 and 0x13 with NCH=4 -> 0x1B then 0x00; all strobes 0.
REQ-033 Write 0x41 to 0x20 -> next cycle uart_tx_data=0x41, uart_tx_wr=4'b0100 for one cycle.
REQ-034 rx_data ch3=0xA5, read 0x30 -> cpu_data_out=0xA5 and uart_rx_rd=4'b1000 next cycle; rd+wr together at 0x30 -> no tx_wr pulse.
REQ-035 IRQ_EN on: write IE ch1=0x01, raise ch1 rx_avail -> IP(0x15)=0x01 and irq=1 one cycle after; write 0x01 to 0x15 -> irq=0; W1C coincident with a new edge -> IP stays 1.
REQ-036 Toggle misc_in bit2 0->1 -> 0x81 bit2=1 after 3 cycles, 0x82=0x04; write 0x04 to 0x82 -> 0x00.
REQ-037 NCH=2: read 0x20 -> 0x00 and no strobe; DIV_W=12: write 0xFF to 0x03 -> read 0x03 returns 0x0F.
